// File: rtl/nibble_serial_alu.sv
// Nibble-serial 32-bit ALU: one 4-bit slice walks the operands a nibble per clock.
// Optional subtract support is compiled in with `define NIBBLE_ALU_SUB_EN.
module nibble_serial_alu (
  input  logic        clk,
  input  logic        rst,
  input  logic        perm_to_count,
  input  logic [2:0]  cmd,
  input  logic [31:0] word1,
  input  logic [31:0] word2,
  output logic        busy,
  output logic [31:0] result,
  output logic        carry
);

  localparam logic [2:0] CMD_ADD   = 3'd0;
`ifdef NIBBLE_ALU_SUB_EN
  localparam logic [2:0] CMD_SUB   = 3'd1;
`endif
  localparam logic [2:0] CMD_AND   = 3'd2;
  localparam logic [2:0] CMD_OR    = 3'd3;
  localparam logic [2:0] CMD_XOR   = 3'd4;
  localparam logic [2:0] CMD_RSHFT = 3'd5;

  logic [2:0] idx;
  logic       done;
  logic       rev;
  logic [2:0] start_idx;
  logic [2:0] last_idx;
  logic       is_latest;
  logic       start_carry;
  logic [3:0] d1;
  logic [3:0] d2;
  logic [3:0] nib;
  logic       co;
  logic [4:0] sum5;

  // RSHFT walks MSB to LSB so the shifted-out bit can ripple downward
  assign rev       = (cmd == CMD_RSHFT);
  assign start_idx = rev ? 3'd7 : 3'd0;
  assign last_idx  = rev ? 3'd0 : 3'd7;
  assign is_latest = (idx == last_idx);
  assign busy      = perm_to_count && !is_latest;

`ifdef NIBBLE_ALU_SUB_EN
  assign start_carry = (cmd == CMD_SUB);
`else
  assign start_carry = 1'b0;
`endif

  assign d1 = word1[{idx, 2'b00} +: 4];
  assign d2 = word2[{idx, 2'b00} +: 4];

  always_comb begin
    nib  = 4'h0;
    co   = carry;
    sum5 = 5'h00;
    case (cmd)
      CMD_ADD: begin
        sum5 = {1'b0, d1} + {1'b0, d2} + {4'b0000, carry};
        nib  = sum5[3:0];
        co   = sum5[4];
      end
`ifdef NIBBLE_ALU_SUB_EN
      CMD_SUB: begin
        sum5 = {1'b0, d1} + {1'b0, ~d2} + {4'b0000, carry};
        nib  = sum5[3:0];
        co   = sum5[4];
      end
`endif
      CMD_AND: nib = d1 & d2;
      CMD_OR:  nib = d1 | d2;
      CMD_XOR: nib = d1 ^ d2;
      CMD_RSHFT: begin
        nib = {carry, d2[3:1]};
        co  = d2[0];
      end
      default: begin
        nib = 4'h0;
        co  = carry;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx    <= 3'd0;
      done   <= 1'b0;
      carry  <= 1'b0;
      result <= 32'h0000_0000;
    end else if (!perm_to_count) begin
      idx   <= start_idx;
      done  <= 1'b0;
      carry <= start_carry;
    end else if (!done) begin
      result[{idx, 2'b00} +: 4] <= nib;
      carry                     <= co;
      if (is_latest) begin
        done <= 1'b1;
      end else if (rev) begin
        idx <= idx - 3'd1;
      end else begin
        idx <= idx + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_nibble_serial_alu.sv
// Directed-vector bench for nibble_serial_alu; expected values are hand-computed.
module tb_nibble_serial_alu;

  logic        clk = 1'b0;
  logic        rst;
  logic        perm_to_count;
  logic [2:0]  cmd;
  logic [31:0] word1;
  logic [31:0] word2;
  logic        busy;
  logic [31:0] result;
  logic        carry;

  int vectors     = 0;
  int miscompares = 0;

  nibble_serial_alu dut (
    .clk           (clk),
    .rst           (rst),
    .perm_to_count (perm_to_count),
    .cmd           (cmd),
    .word1         (word1),
    .word2         (word2),
    .busy          (busy),
    .result        (result),
    .carry         (carry)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Setup edge, then 8 run edges; counts busy cycles seen before each edge.
  task automatic run_op(input string tag, input logic [2:0] c, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input logic exp_c);
    int busy_cnt;
    perm_to_count = 1'b0;
    cmd   = c;
    word1 = a;
    word2 = b;
    step();
    chk({tag, "_busy_idle"}, {31'd0, busy}, 32'd0);
    perm_to_count = 1'b1;
    #1;
    busy_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (busy) busy_cnt++;
      step();
    end
    chk({tag, "_result"}, result, exp_res);
    chk({tag, "_carry"}, {31'd0, carry}, {31'd0, exp_c});
    chk({tag, "_busy_cycles"}, busy_cnt, 32'd7);
    chk({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    perm_to_count = 1'b0;
    cmd   = 3'd0;
    word1 = 32'h0;
    word2 = 32'h0;
    #1;
    chk("reset_result", result, 32'h0);
    chk("reset_carry", {31'd0, carry}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    step();
    step();
    rst = 1'b0;
    step();

    run_op("add1", 3'd0, 32'hEFFF_FFFF, 32'h0000_0001, 32'hF000_0000, 1'b0);
    run_op("add2", 3'd0, 32'hFFFF_0FFF, 32'h0000_0002, 32'hFFFF_1001, 1'b0);
    run_op("rshft", 3'd5, 32'hDEAD_BEEF, 32'h0600_0000, 32'h0300_0000, 1'b0);
    run_op("rshft_lsb", 3'd5, 32'h1234_5678, 32'h8000_0003, 32'h4000_0001, 1'b1);
`ifdef NIBBLE_ALU_SUB_EN
    run_op("sub1", 3'd1, 32'h0000_0010, 32'h0000_0001, 32'h0000_000F, 1'b1);
    run_op("sub2", 3'd1, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0);
`else
    run_op("sub_off", 3'd1, 32'h0000_0010, 32'h0000_0001, 32'h0000_0000, 1'b0);
`endif
    run_op("and", 3'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0);
    run_op("or", 3'd3, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b0);
    run_op("xor", 3'd4, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0);
    for (int i = 0; i < 3; i++) step();
    chk("xor_hold_result", result, 32'h0FF0_0FF0);
    chk("xor_hold_carry", {31'd0, carry}, 32'd0);
    chk("xor_hold_busy", {31'd0, busy}, 32'd0);

    run_op("reserved", 3'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0);

    // abort after 3 edges: partial result held, busy drops at once
    perm_to_count = 1'b0;
    cmd   = 3'd0;
    word1 = 32'h1111_1111;
    word2 = 32'h2222_2222;
    step();
    perm_to_count = 1'b1;
    for (int i = 0; i < 3; i++) step();
    perm_to_count = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    step();
    step();
    chk("abort_result", result, 32'h0000_0333);

    // async reset after the 4th run edge
    cmd   = 3'd0;
    word1 = 32'h9876_FFF8;
    word2 = 32'h1111_000F;
    step();
    perm_to_count = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("pre_rst_partial", result, 32'h0000_0007);
    chk("pre_rst_carry", {31'd0, carry}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_mid_result", result, 32'h0);
    chk("rst_mid_carry", {31'd0, carry}, 32'd0);
    chk("rst_mid_busy", {31'd0, busy}, 32'd1);
    step();
    rst = 1'b0;
    run_op("add_rerun", 3'd0, 32'h9876_FFF8, 32'h1111_000F, 32'hA988_0007, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
